// File: rtl/clock_pkg.sv
// Shared definitions for the clock edit front-end: state encoding, field codes,
// BCD limits and the wrap-around BCD step helpers.
package clock_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDIT_HR,
    S_EDIT_MN,
    S_EDIT_SD,
    S_LOAD
  } state_t;

  localparam logic [1:0] F_NONE = 2'd0;
  localparam logic [1:0] F_HR   = 2'd1;
  localparam logic [1:0] F_MN   = 2'd2;
  localparam logic [1:0] F_SD   = 2'd3;

  localparam logic [7:0] HR_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

  // Valid BCD digits compare in the same order as binary, so val <= max is a direct check.
  function automatic logic bcd_valid(input logic [7:0] val, input logic [7:0] max);
    return (val[3:0] <= 4'd9) && (val[7:4] <= 4'd9) && (val <= max);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
    logic [7:0] res;
    if (!bcd_valid(val, max) || (val == max))
      res = 8'h00;
    else if (val[3:0] == 4'd9)
      res = {val[7:4] + 4'd1, 4'd0};
    else
      res = {val[7:4], val[3:0] + 4'd1};
    return res;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] val, input logic [7:0] max);
    logic [7:0] res;
    if (!bcd_valid(val, max))
      res = 8'h00;
    else if (val == 8'h00)
      res = max;
    else if (val[3:0] == 4'd0)
      res = {val[7:4] - 4'd1, 4'd9};
    else
      res = {val[7:4], val[3:0] - 4'd1};
    return res;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key to one-cycle press pulse: two-stage synchroniser, stability
// counter, then a falling-edge detect on the accepted level.
module key_debounce
  import clock_pkg::*;
#(
  parameter logic [19:0] DEB_MAX = 20'd1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  logic        key_p0;
  logic        key_p1;
  logic        level;
  logic        level_d;
  logic [19:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_p0  <= 1'b1;
      key_p1  <= 1'b1;
      level   <= 1'b1;
      level_d <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      key_p0  <= key_n;
      key_p1  <= key_p0;
      level_d <= level;
      press   <= level_d & ~level;
      // Any bounce back to the accepted level restarts the stability window.
      if (key_p1 == level)
        cnt <= '0;
      else if (cnt == DEB_MAX - 20'd1) begin
        level <= key_p1;
        cnt   <= '0;
      end else
        cnt <= cnt + 20'd1;
    end
  end

endmodule

// File: rtl/time_setter.sv
// Edit front-end for the digital clock: snapshots the running time on entry to set
// mode, steps the selected BCD field from debounced keys and strobes a load on OK.
module time_setter
  import clock_pkg::*;
#(
  parameter logic [19:0] DEB_MAX   = 20'd1_000_000,
  parameter logic [24:0] BLINK_MAX = 25'd25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_mod,
  input  logic       key_sel_n,
  input  logic       key_inc_n,
  input  logic       key_dec_n,
  input  logic       key_ok_n,
  input  logic [7:0] hr,
  input  logic [7:0] mn,
  input  logic [7:0] sd,
  output logic [7:0] hr_cal,
  output logic [7:0] mn_cal,
  output logic [7:0] sd_cal,
  output logic       time_add,
  output logic [1:0] field,
  output logic       blink
);

  logic        sel_press;
  logic        inc_press;
  logic        dec_press;
  logic        ok_press;
  logic        set_mod_d;
  logic [24:0] blink_cnt;
  state_t      state;

  key_debounce #(.DEB_MAX(DEB_MAX)) u_deb_sel (.clk(clk), .rst(rst), .key_n(key_sel_n), .press(sel_press));
  key_debounce #(.DEB_MAX(DEB_MAX)) u_deb_inc (.clk(clk), .rst(rst), .key_n(key_inc_n), .press(inc_press));
  key_debounce #(.DEB_MAX(DEB_MAX)) u_deb_dec (.clk(clk), .rst(rst), .key_n(key_dec_n), .press(dec_press));
  key_debounce #(.DEB_MAX(DEB_MAX)) u_deb_ok  (.clk(clk), .rst(rst), .key_n(key_ok_n),  .press(ok_press));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      set_mod_d <= 1'b0;
      hr_cal    <= 8'h00;
      mn_cal    <= 8'h00;
      sd_cal    <= 8'h00;
      time_add  <= 1'b0;
      field     <= F_NONE;
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else begin
      set_mod_d <= set_mod;
      time_add  <= 1'b0;
      if (!set_mod) begin
        // Abandon: cal registers keep whatever was being edited.
        state     <= S_IDLE;
        field     <= F_NONE;
        blink     <= 1'b0;
        blink_cnt <= '0;
      end else begin
        if (state == S_IDLE) begin
          blink     <= 1'b0;
          blink_cnt <= '0;
        end else if (blink_cnt == BLINK_MAX - 25'd1) begin
          blink     <= ~blink;
          blink_cnt <= '0;
        end else
          blink_cnt <= blink_cnt + 25'd1;

        case (state)
          S_IDLE: begin
            if (!set_mod_d) begin
              hr_cal <= hr;
              mn_cal <= mn;
              sd_cal <= sd;
              state  <= S_EDIT_HR;
              field  <= F_HR;
            end
          end
          S_EDIT_HR, S_EDIT_MN, S_EDIT_SD: begin
            // One action per cycle, ok > sel > inc > dec.
            if (ok_press) begin
              state    <= S_LOAD;
              time_add <= 1'b1;
            end else if (sel_press) begin
              case (state)
                S_EDIT_HR: begin state <= S_EDIT_MN; field <= F_MN; end
                S_EDIT_MN: begin state <= S_EDIT_SD; field <= F_SD; end
                default:   begin state <= S_EDIT_HR; field <= F_HR; end
              endcase
            end else if (inc_press) begin
              case (state)
                S_EDIT_HR: hr_cal <= bcd_inc(hr_cal, HR_MAX);
                S_EDIT_MN: mn_cal <= bcd_inc(mn_cal, MS_MAX);
                default:   sd_cal <= bcd_inc(sd_cal, MS_MAX);
              endcase
            end else if (dec_press) begin
              case (state)
                S_EDIT_HR: hr_cal <= bcd_dec(hr_cal, HR_MAX);
                S_EDIT_MN: mn_cal <= bcd_dec(mn_cal, MS_MAX);
                default:   sd_cal <= bcd_dec(sd_cal, MS_MAX);
              endcase
            end
          end
          S_LOAD: begin
            state <= S_EDIT_HR;
            field <= F_HR;
          end
          default: begin
            state <= S_IDLE;
            field <= F_NONE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_time_setter.sv
// Bench for time_setter: directed scenarios plus random key traffic, checked against
// a transaction-level model that steps fields with decimal arithmetic.
module tb_time_setter;

  localparam logic [19:0] DEB = 20'd4;
  localparam logic [24:0] BLK = 25'd8;
  localparam int BLK_I = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       set_mod;
  logic       key_sel_n, key_inc_n, key_dec_n, key_ok_n;
  logic [7:0] hr, mn, sd;
  logic [7:0] hr_cal, mn_cal, sd_cal;
  logic       time_add;
  logic [1:0] field;
  logic       blink;

  time_setter #(.DEB_MAX(DEB), .BLINK_MAX(BLK)) dut (
    .clk(clk), .rst(rst), .set_mod(set_mod),
    .key_sel_n(key_sel_n), .key_inc_n(key_inc_n), .key_dec_n(key_dec_n), .key_ok_n(key_ok_n),
    .hr(hr), .mn(mn), .sd(sd),
    .hr_cal(hr_cal), .mn_cal(mn_cal), .sd_cal(sd_cal),
    .time_add(time_add), .field(field), .blink(blink)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ta_count = 0;
  logic [7:0] ta_hr, ta_mn, ta_sd;

  // Reference model state
  logic [7:0] m_hr, m_mn, m_sd;
  int m_field;
  int m_ta;
  int entry_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (time_add) begin
      ta_count <= ta_count + 1;
      ta_hr    <= hr_cal;
      ta_mn    <= mn_cal;
      ta_sd    <= sd_cal;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bcd2i(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] i2bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  // Decimal wrap-around step over 0..lim-1; anything not a legal value becomes 00.
  function automatic logic [7:0] step(input logic [7:0] v, input int lim, input int dir);
    if (v[3:0] > 4'd9 || v[7:4] > 4'd9 || bcd2i(v) >= lim) return 8'h00;
    return i2bcd((bcd2i(v) + dir + lim) % lim);
  endfunction

  task automatic bump(input int dir);
    case (m_field)
      1: m_hr = step(m_hr, 24, dir);
      2: m_mn = step(m_mn, 60, dir);
      3: m_sd = step(m_sd, 60, dir);
      default: ;
    endcase
  endtask

  // mask bits: {ok, sel, inc, dec}
  task automatic model_press(input logic [3:0] mask);
    if (m_field != 0) begin
      if (mask[3]) begin
        m_ta++;
        m_field = 1;
      end else if (mask[2])
        m_field = (m_field == 3) ? 1 : m_field + 1;
      else if (mask[1])
        bump(1);
      else if (mask[0])
        bump(-1);
    end
  endtask

  task automatic step_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_keys();
    key_ok_n = 1'b1; key_sel_n = 1'b1; key_inc_n = 1'b1; key_dec_n = 1'b1;
  endtask

  task automatic press(input logic [3:0] mask, input int hold);
    key_ok_n  = ~mask[3];
    key_sel_n = ~mask[2];
    key_inc_n = ~mask[1];
    key_dec_n = ~mask[0];
    step_clk(hold);
    release_keys();
    step_clk(10);
    model_press(mask);
  endtask

  task automatic enter(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    set_mod = 1'b0;
    hr = h; mn = m; sd = s;
    step_clk(2);
    set_mod = 1'b1;
    step_clk(1);
    entry_cyc = cyc;
    m_hr = h; m_mn = m; m_sd = s;
    m_field = 1;
  endtask

  task automatic check_all(input string tag);
    int exp_blink;
    exp_blink = (m_field == 0) ? 0 : ((cyc - entry_cyc) / BLK_I) % 2;
    chk({tag, ".field"}, 32'(field), 32'(m_field));
    chk({tag, ".hr_cal"}, 32'(hr_cal), 32'(m_hr));
    chk({tag, ".mn_cal"}, 32'(mn_cal), 32'(m_mn));
    chk({tag, ".sd_cal"}, 32'(sd_cal), 32'(m_sd));
    chk({tag, ".loads"}, 32'(ta_count), 32'(m_ta));
    chk({tag, ".blink"}, 32'(blink), 32'(exp_blink));
  endtask

  initial begin
    rst = 1'b1;
    set_mod = 1'b0;
    release_keys();
    hr = 8'h00; mn = 8'h00; sd = 8'h00;
    m_hr = 8'h00; m_mn = 8'h00; m_sd = 8'h00;
    m_field = 0; m_ta = 0; entry_cyc = 0;
    step_clk(3);
    check_all("reset");
    chk("reset.time_add", 32'(time_add), 32'd0);
    rst = 1'b0;
    step_clk(2);

    // Entry snapshot
    enter(8'h12, 8'h34, 8'h56);
    check_all("entry");
    chk("entry.time_add", 32'(time_add), 32'd0);

    // Held increment: exactly one step, accepted DEB_MAX+3 cycles after going low
    enter(8'h23, 8'h59, 8'h00);
    key_inc_n = 1'b0;
    step_clk(7);
    chk("inc_lat.before", 32'(hr_cal), 32'h23);
    step_clk(1);
    chk("inc_lat.after", 32'(hr_cal), 32'h00);
    step_clk(12);
    release_keys();
    step_clk(10);
    model_press(4'b0010);
    check_all("inc_hold");
    press(4'b0001, 10);
    check_all("dec_wrap_hr");

    // Field select and minute/second wrap
    press(4'b0100, 10);
    check_all("sel_mn");
    press(4'b0010, 10);
    check_all("inc_wrap_mn");
    press(4'b0100, 10);
    check_all("sel_sd");
    press(4'b0001, 10);
    check_all("dec_wrap_sd");
    press(4'b0100, 10);
    check_all("sel_hr");

    // Commit
    press(4'b1000, 10);
    check_all("ok");
    chk("ok.hr", 32'(ta_hr), 32'(m_hr));
    chk("ok.mn", 32'(ta_mn), 32'(m_mn));
    chk("ok.sd", 32'(ta_sd), 32'(m_sd));

    // Simultaneous ok+inc, then a short glitch
    press(4'b1010, 11);
    check_all("ok_inc");
    key_inc_n = 1'b0;
    step_clk(2);
    release_keys();
    step_clk(10);
    check_all("glitch");

    // Invalid snapshot forced to 00
    enter(8'h3A, 8'h61, 8'hF5);
    press(4'b0010, 10);
    press(4'b0100, 10);
    press(4'b0001, 10);
    press(4'b0100, 10);
    press(4'b0010, 10);
    check_all("invalid");

    // Abandon mid-edit, then presses while idle
    press(4'b0100, 10);
    set_mod = 1'b0;
    step_clk(1);
    m_field = 0;
    check_all("abandon");
    press(4'b0010, 10);
    press(4'b1000, 10);
    check_all("idle_keys");

    // Asynchronous reset mid-edit
    enter(8'h07, 8'h08, 8'h09);
    press(4'b0010, 10);
    step_clk(3);
    set_mod = 1'b0;
    rst = 1'b1;
    #1;
    m_hr = 8'h00; m_mn = 8'h00; m_sd = 8'h00; m_field = 0;
    check_all("rst_mid");
    chk("rst_mid.time_add", 32'(time_add), 32'd0);
    step_clk(2);
    rst = 1'b0;
    step_clk(2);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      int r;
      logic [3:0] mask;
      r = int'($urandom_range(0, 11));
      if (r == 0)
        enter(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      else if (r == 1 || m_field == 0)
        enter(i2bcd(int'($urandom_range(0, 23))), i2bcd(int'($urandom_range(0, 59))),
              i2bcd(int'($urandom_range(0, 59))));
      else if (r == 2) begin
        set_mod = 1'b0;
        step_clk(1);
        m_field = 0;
        press(4'b0010, 10);
      end else begin
        if (r == 3)
          mask = 4'($urandom_range(1, 15));
        else
          mask = 4'b0001 << $urandom_range(0, 3);
        press(mask, int'($urandom_range(9, 14)));
      end
      check_all($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
